// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: legacy opcode/width defines,
// sequencer state encoding and the NOP instruction word.
`ifndef FETCH_SEQUENCER_DEFINES
`define FETCH_SEQUENCER_DEFINES
`define PM_ID_INS_WIDTH 6
`define OPCODE_NOP  4'h0
`define OPCODE_LOAD 4'h1
`define OPCODE_ADD  4'h2
`define OPCODE_SUB  4'h3
`define OPCODE_JMP  4'h4
`define OPCODE_OUT  4'h5
`endif

package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fs_state_t;

    localparam int unsigned OPCODE_W = 4;

    // Instruction word = {opcode, 2-bit operand}
    localparam logic [`PM_ID_INS_WIDTH-1:0] NOP_INS = {`OPCODE_NOP, 2'b00};

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns PC and IR, provides run/step/halt control,
// jump redirect and downstream stall handling in front of program memory.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INS_W     = `PM_ID_INS_WIDTH,
    parameter int unsigned LAST_ADDR = 31,
    parameter bit          WRAP_EN   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              restart,
    input  logic              stall,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [INS_W-1:0]  pm_ins,
    output logic [INS_W-1:0]  ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [INS_W-1:0]  NOP  = INS_W'(NOP_INS);

    fs_state_t         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [INS_W-1:0]  ir_n;
    logic [ADDR_W-1:0] ir_pc_n;
    logic              ir_valid_n;
    logic              fire;

    assign pm_addr = pc;

    assign fire = !stall && !jmp_valid &&
                  (((state == FS_RUN) && run_en) || ((state == FS_IDLE) && step_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_IDLE;
            pc       <= '0;
            ir       <= NOP;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
            halted   <= (state_n == FS_HALT);
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ir_pc_n    = ir_pc;
        ir_valid_n = 1'b0;

        if (restart) begin
            pc_n    = '0;
            state_n = FS_IDLE;
        end else if (state != FS_HALT) begin
            if (halt_req) begin
                state_n = FS_HALT;
            end else begin
                // run_en governs IDLE<->RUN independently of jump/stall;
                // end-of-program below may still override to HALT.
                if ((state == FS_IDLE) && run_en) begin
                    state_n = FS_RUN;
                end else if ((state == FS_RUN) && !run_en) begin
                    state_n = FS_IDLE;
                end

                if (jmp_valid) begin
                    pc_n = jmp_addr;
                end else if (stall) begin
                    ir_valid_n = ir_valid;
                end else if (fire) begin
                    ir_n       = pm_ins;
                    ir_pc_n    = pc;
                    ir_valid_n = 1'b1;
                    if (pc == LAST) begin
                        if (WRAP_EN) begin
                            pc_n = '0;
                        end else begin
                            state_n = FS_HALT;
                        end
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: table-driven vectors plus hand-written wrap and reset
// sequences, run against a non-wrapping and a wrapping instance in parallel.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, run_en, step_req, halt_req, restart, stall, jmp_valid;
    logic [4:0] jmp_addr;

    logic [4:0] pm_addr0, ir_pc0, pm_addr1, ir_pc1;
    logic [5:0] pm_ins0, ir0, pm_ins1, ir1;
    logic       ir_valid0, halted0, ir_valid1, halted1;

    logic [5:0] pm [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign pm_ins0 = pm[pm_addr0];
    assign pm_ins1 = pm[pm_addr1];

    fetch_sequencer #(.ADDR_W(5), .INS_W(6), .LAST_ADDR(31), .WRAP_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
        .halt_req(halt_req), .restart(restart), .stall(stall),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .pm_addr(pm_addr0),
        .pm_ins(pm_ins0), .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0),
        .halted(halted0)
    );

    fetch_sequencer #(.ADDR_W(5), .INS_W(6), .LAST_ADDR(31), .WRAP_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
        .halt_req(halt_req), .restart(restart), .stall(stall),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .pm_addr(pm_addr1),
        .pm_ins(pm_ins1), .ir(ir1), .ir_pc(ir_pc1), .ir_valid(ir_valid1),
        .halted(halted1)
    );

    typedef struct {
        logic       run, step, halt, rs, stl, jv;
        logic [4:0] ja;
        logic [4:0] e_addr, e_irpc;
        logic       e_valid, e_halted, e_nop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic run, step, halt, rs, stl, jv, input int ja,
                       input int e_addr, e_irpc, input logic e_valid, e_halted, e_nop);
        vec_t v;
        v.run = run; v.step = step; v.halt = halt; v.rs = rs; v.stl = stl; v.jv = jv;
        v.ja = 5'(ja); v.e_addr = 5'(e_addr); v.e_irpc = 5'(e_irpc);
        v.e_valid = e_valid; v.e_halted = e_halted; v.e_nop = e_nop;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic run, step, halt, rs, stl, jv, input logic [4:0] ja);
        run_en = run; step_req = step; halt_req = halt; restart = rs;
        stall = stl; jmp_valid = jv; jmp_addr = ja;
    endtask

    // Outputs are sampled on the falling edge after the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk0(input string nm, input int addr, irpc, input logic valid, hlt);
        chk({nm, ".pm_addr"}, 32'(pm_addr0), 32'(addr));
        chk({nm, ".ir_pc"}, 32'(ir_pc0), 32'(irpc));
        chk({nm, ".ir_valid"}, 32'(ir_valid0), 32'(valid));
        chk({nm, ".halted"}, 32'(halted0), 32'(hlt));
    endtask

    task automatic chk1(input string nm, input int addr, irpc, input logic valid, hlt);
        chk({nm, ".w.pm_addr"}, 32'(pm_addr1), 32'(addr));
        chk({nm, ".w.ir_pc"}, 32'(ir_pc1), 32'(irpc));
        chk({nm, ".w.ir_valid"}, 32'(ir_valid1), 32'(valid));
        chk({nm, ".w.halted"}, 32'(halted1), 32'(hlt));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pm[i] = 6'((i * 37 + 11) % 64);

        // Free run from reset: one cycle to enter RUN, then 17 fetches
        add(1,0,0,0,0,0,0, 0,0,0,0,1);
        for (int k = 0; k < 17; k++) add(1,0,0,0,0,0,0, k+1,k,1,0,0);
        add(0,0,0,0,0,0,0, 17,16,0,0,0);
        add(0,0,0,1,0,0,0, 0,16,0,0,0);
        // Three single steps, four cycles apart
        for (int s = 0; s < 3; s++) begin
            add(0,1,0,0,0,0,0, s+1,s,1,0,0);
            for (int j = 0; j < 3; j++) add(0,0,0,0,0,0,0, s+1,s,0,0,0);
        end
        // Stall at PC=5, then jump-with-stall at PC=7
        add(0,0,0,1,0,0,0, 0,2,0,0,0);
        add(1,0,0,0,0,0,0, 0,2,0,0,0);
        for (int k = 0; k < 5; k++) add(1,0,0,0,0,0,0, k+1,k,1,0,0);
        for (int j = 0; j < 3; j++) add(1,0,0,0,1,0,0, 5,4,1,0,0);
        add(1,0,0,0,0,0,0, 6,5,1,0,0);
        add(1,0,0,0,0,0,0, 7,6,1,0,0);
        add(1,0,0,0,1,1,2, 2,6,0,0,0);
        add(1,0,0,0,0,0,0, 3,2,1,0,0);
        // halt_req, then everything but restart ignored in HALT
        add(1,0,1,0,0,0,0, 3,2,0,1,0);
        add(1,1,0,0,1,1,9, 3,2,0,1,0);
        add(0,0,0,1,0,0,0, 0,2,0,0,0);

        rst = 1'b1;
        drive(0,0,0,0,0,0,5'd0);
        tick(); tick();
        chk("reset.ir", 32'(ir0), 32'(NOP_INS));
        chk0("reset", 0, 0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].run, vq[i].step, vq[i].halt, vq[i].rs, vq[i].stl, vq[i].jv, vq[i].ja);
            tick();
            chk0($sformatf("v%0d", i), int'(vq[i].e_addr), int'(vq[i].e_irpc),
                 vq[i].e_valid, vq[i].e_halted);
            chk($sformatf("v%0d.ir", i), 32'(ir0),
                vq[i].e_nop ? 32'(NOP_INS) : 32'(pm[vq[i].e_irpc]));
        end

        // End of program: halt without wrap, continue with wrap
        drive(0,0,0,0,0,1,5'd30); tick();
        chk0("eop.jmp", 30, 2, 1'b0, 1'b0); chk1("eop.jmp", 30, 2, 1'b0, 1'b0);
        drive(1,0,0,0,0,0,5'd0); tick();
        chk0("eop.run", 30, 2, 1'b0, 1'b0);
        tick();
        chk0("eop.f30", 31, 30, 1'b1, 1'b0); chk1("eop.f30", 31, 30, 1'b1, 1'b0);
        chk("eop.f30.ir", 32'(ir0), 32'(pm[30]));
        tick();
        chk0("eop.f31", 31, 31, 1'b1, 1'b1); chk1("eop.f31", 0, 31, 1'b1, 1'b0);
        chk("eop.f31.ir", 32'(ir0), 32'(pm[31]));
        tick();
        chk0("eop.h1", 31, 31, 1'b0, 1'b1); chk1("eop.f0", 1, 0, 1'b1, 1'b0);
        chk("eop.f0.ir", 32'(ir1), 32'(pm[0]));
        tick();
        chk0("eop.h2", 31, 31, 1'b0, 1'b1); chk1("eop.f1", 2, 1, 1'b1, 1'b0);
        drive(0,0,0,1,0,0,5'd0); tick();
        chk0("eop.rs", 0, 31, 1'b0, 1'b0); chk1("eop.rs", 0, 1, 1'b0, 1'b0);

        // Synchronous reset mid-run discards a simultaneous jump
        drive(1,0,0,0,0,0,5'd0); tick();
        for (int k = 0; k < 9; k++) tick();
        chk0("rst.pre", 9, 8, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1,0,0,0,0,1,5'd20); tick();
        chk0("rst.mid", 0, 0, 1'b0, 1'b0);
        chk("rst.mid.ir", 32'(ir0), 32'(NOP_INS));
        rst = 1'b0;
        drive(0,1,0,0,0,0,5'd0); tick();
        chk0("rst.step", 1, 0, 1'b1, 1'b0);
        chk("rst.step.ir", 32'(ir0), 32'(pm[0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
